bin2bcd_seq: RTL

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

---
 rtl/bin2bcd_seq_pkg.sv | 8 +
 rtl/bcd_digit_adj.sv | 7 +
 rtl/bin2bcd_seq.sv | 81 ++++++++
 3 files changed

// File: rtl/bin2bcd_seq_pkg.sv
// bin2bcd_seq_pkg: shared sizes and FSM state type for the sequential binary-to-BCD converter
package bin2bcd_seq_pkg;
   localparam int N_DIGITS     = 6;
   localparam int BIN_W        = 20;
   localparam int SHIFT_CYCLES = 20;
   localparam int CNT_W        = 5;
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: double-dabble correction cell, adds 3 to a BCD digit that is 5 or more
module bcd_digit_adj (
   input  logic [3:0] d,
   output logic [3:0] q
);
   assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: 20-bit binary to 6-digit BCD via one double-dabble shift per clock,
// with change-detect self start and a one-deep pending buffer for requests made while busy
module bin2bcd_seq
   import bin2bcd_seq_pkg::*;
#(
   parameter bit               CHANGE_DET = 1'b1,
   parameter logic [BIN_W-1:0] SAT_VAL    = 20'd999_999
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [BIN_W-1:0]      data_in,
   input  logic                  data_vld,
   output logic [4*N_DIGITS-1:0] bcd,
   output logic                  bcd_vld,
   output logic                  busy,
   output logic                  ovf
);
   state_t                          state;
   logic [CNT_W-1:0]                cnt;
   logic [BIN_W-1:0]                sr, last_val, pend_val, operand;
   logic [4*N_DIGITS-1:0]           dig, dig_adj;
   logic [4*N_DIGITS+BIN_W-1:0]     cat;
   logic                            pend_full, ovf_int, start;
   // a value already queued does not count as a change, so a held input cannot retrigger
   assign start   = data_vld | (CHANGE_DET && data_in != last_val && !(pend_full && data_in == pend_val));
   assign operand = pend_full ? pend_val : data_in;
   assign cat     = {dig_adj, sr} << 1;
   for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (.d(dig[4*g+:4]), .q(dig_adj[4*g+:4]));
   end
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         cnt       <= '0;
         sr        <= '0;
         dig       <= '0;
         last_val  <= '0;
         pend_val  <= '0;
         pend_full <= 1'b0;
         ovf_int   <= 1'b0;
         bcd       <= '0;
         bcd_vld   <= 1'b0;
         busy      <= 1'b0;
         ovf       <= 1'b0;
      end else begin
         bcd_vld <= 1'b0;
         case (state)
            IDLE: if (start || pend_full) begin
               state     <= SHIFT;
               busy      <= 1'b1;
               last_val  <= operand;
               sr        <= operand > SAT_VAL ? SAT_VAL : operand;
               ovf_int   <= operand > SAT_VAL;
               dig       <= '0;
               cnt       <= '0;
               pend_full <= pend_full && start;
               if (pend_full && start) pend_val <= data_in;
            end
            SHIFT: begin
               {dig, sr} <= cat;
               cnt       <= cnt + 5'd1;
               if (cnt == CNT_W'(SHIFT_CYCLES - 1)) begin
                  state   <= DONE;
                  bcd     <= cat[4*N_DIGITS+BIN_W-1:BIN_W];
                  ovf     <= ovf_int;
                  bcd_vld <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
         if (state != IDLE && start) begin
            pend_val  <= data_in;
            pend_full <= 1'b1;
         end
      end
   end
endmodule
